// File: rtl/iir_drv_pkg.sv
// Shared types and constants for the IIR filter stream driver.
package iir_drv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        CAPT = 2'd2
    } state_t;

    localparam int unsigned ERR_CNT_W = 16;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/iir_drv_fifo.sv
// Synchronous input FIFO with full/empty flags; head is visible combinationally on rd_data.
module iir_drv_fifo
    import iir_drv_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [BIT_WIDTH-1:0] wr_data,
    input  logic                 pop,
    output logic [BIT_WIDTH-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);

    logic [BIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/filter_iir_stream_driver.sv
// Sample-rate driver feeding a one-cycle IIR filter from a stream FIFO and returning results on a stream.
// Optional ERR_CNT port and counter enabled by defining IIR_DRV_ERR_CNT_EN.
module filter_iir_stream_driver
    import iir_drv_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned CLK_DIV    = 100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 EN,
    input  logic [BIT_WIDTH-1:0] S_DATA,
    input  logic                 S_VALID,
    output logic                 S_READY,
    output logic [BIT_WIDTH-1:0] M_DATA,
    output logic                 M_VALID,
    input  logic                 M_READY,
    output logic                 FILT_START,
    output logic [BIT_WIDTH-1:0] FILT_DIN,
    input  logic [BIT_WIDTH-1:0] FILT_DOUT,
    output logic                 UNDERRUN,
    output logic                 OVERRUN
`ifdef IIR_DRV_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 tick;
    logic                 launch;
    logic                 capt;
    logic [BIT_WIDTH-1:0] head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [BIT_WIDTH-1:0] din_q;
    logic [BIT_WIDTH-1:0] hold_q;
    logic [BIT_WIDTH-1:0] mdata_q;
    logic                 mvalid_q;
    logic                 und_q;
    logic                 ovr_q;

    assign tick   = EN && (cnt_q == CNT_W'(CLK_DIV - 1));
    assign launch = (state_q == IDLE) && tick;
    assign capt   = (state_q == CAPT);

    iir_drv_fifo #(
        .BIT_WIDTH (BIT_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst_n  (nRST),
        .push   (S_VALID),
        .wr_data(S_DATA),
        .pop    (launch),
        .rd_data(head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (EN) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = FIRE;
            FIRE:    state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An empty FIFO at launch repeats the last sample (zero-order hold) and flags underrun during FIRE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            din_q  <= '0;
            hold_q <= '0;
            und_q  <= 1'b0;
        end else begin
            und_q <= launch && fifo_empty;
            if (launch) begin
                if (!fifo_empty) begin
                    din_q  <= head;
                    hold_q <= head;
                end else begin
                    din_q <= hold_q;
                end
            end
        end
    end

    // Capture wins over a same-cycle consumer handshake so fresh data is never dropped.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mdata_q  <= '0;
            mvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= capt && mvalid_q && !M_READY;
            if (capt) begin
                mdata_q  <= FILT_DOUT;
                mvalid_q <= 1'b1;
            end else if (mvalid_q && M_READY) begin
                mvalid_q <= 1'b0;
            end
        end
    end

`ifdef IIR_DRV_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q <= '0;
        end else if ((und_q || ovr_q) && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign ERR_CNT = err_q;
`endif

    assign S_READY    = !fifo_full;
    assign FILT_START = (state_q == FIRE);
    assign FILT_DIN   = din_q;
    assign M_DATA     = mdata_q;
    assign M_VALID    = mvalid_q;
    assign UNDERRUN   = und_q;
    assign OVERRUN    = ovr_q;

endmodule

// File: tb/tb_filter_iir_stream_driver.sv
// Scoreboard bench for filter_iir_stream_driver with a pass-through one-cycle filter model.
module tb_filter_iir_stream_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        filt_start;
    logic [15:0] filt_din;
    logic [15:0] filt_dout;
    logic        underrun;
    logic        overrun;
`ifdef IIR_DRV_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out_count = 0;
    int und_count = 0;
    int ovr_count = 0;
    logic prev_und = 1'b0;
    logic prev_ovr = 1'b0;

    logic signed [15:0] exp_din[$];
    logic signed [15:0] exp_out[$];

    filter_iir_stream_driver #(
        .BIT_WIDTH (16),
        .CLK_DIV   (8),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK       (clk),
        .nRST      (rst_n),
        .EN        (en),
        .S_DATA    (s_data),
        .S_VALID   (s_valid),
        .S_READY   (s_ready),
        .M_DATA    (m_data),
        .M_VALID   (m_valid),
        .M_READY   (m_ready),
        .FILT_START(filt_start),
        .FILT_DIN  (filt_din),
        .FILT_DOUT (filt_dout),
        .UNDERRUN  (underrun),
        .OVERRUN   (overrun)
`ifdef IIR_DRV_ERR_CNT_EN
        ,
        .ERR_CNT   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pass-through filter: DATA_OUT follows DATA_IN one cycle after START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) filt_dout <= '0;
        else if (filt_start) filt_dout <= filt_din;
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                check("out_expected", exp_out.size() > 0, 1);
                if (exp_out.size() > 0) check("m_data", $signed(m_data), exp_out.pop_front());
                out_count++;
            end
            if (filt_start) begin
                check("din_expected", exp_din.size() > 0, 1);
                if (exp_din.size() > 0) check("filt_din", $signed(filt_din), exp_din.pop_front());
            end
            if (underrun) begin
                und_count++;
                check("underrun_width", prev_und, 0);
            end
            if (overrun) begin
                ovr_count++;
                check("overrun_width", prev_ovr, 0);
            end
            prev_und = underrun;
            prev_ovr = overrun;
        end else begin
            prev_und = 1'b0;
            prev_ovr = 1'b0;
        end
    end

    task automatic push_sample(input logic signed [15:0] d);
        bit done = 0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (s_ready) done = 1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("push_accepted", done, 1);
    endtask

    task automatic wait_start(input string name, output int at);
        bit seen = 0;
        at = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (filt_start) begin
                seen = 1;
                at = cyc;
            end
        end
        check(name, seen, 1);
    endtask

    // which: 0 = outputs, 1 = underruns, 2 = overruns
    task automatic wait_count(input string name, input int which, input int n);
        bit reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            @(posedge clk);
            case (which)
                0:       reached = (out_count >= n);
                1:       reached = (und_count >= n);
                default: reached = (ovr_count >= n);
            endcase
        end
        #1;
        check(name, reached, 1);
    endtask

    initial begin
        int t0, t1, t2, n;
        bit seen;
        logic prev_ready;

        rst_n = 1'b0; en = 1'b0; s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_filt_start", filt_start, 0);
        check("rst_filt_din", filt_din, 0);
        check("rst_underrun", underrun, 0);
        check("rst_overrun", overrun, 0);
`ifdef IIR_DRV_ERR_CNT_EN
        check("rst_err_cnt", err_cnt, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Three samples, start period and 2-cycle latency to M_DATA
        push_sample(100);  exp_din.push_back(100);  exp_out.push_back(100);
        push_sample(-200); exp_din.push_back(-200); exp_out.push_back(-200);
        push_sample(300);  exp_din.push_back(300);  exp_out.push_back(300);
        en = 1'b1;
        wait_start("start0_seen", t0);
        wait_start("start1_seen", t1);
        wait_start("start2_seen", t2);
        check("start_period_a", t1 - t0, 8);
        check("start_period_b", t2 - t1, 8);
        repeat (2) @(negedge clk);
        check("lat_m_valid", m_valid, 1);
        check("lat_m_data", $signed(m_data), 300);
        wait_count("out3", 0, 3);
        en = 1'b0;

        // FIFO fill with EN=0: four pushes then back-pressure
        exp_din.push_back(11); exp_din.push_back(12); exp_din.push_back(13); exp_din.push_back(14);
        exp_out.push_back(11); exp_out.push_back(12); exp_out.push_back(13); exp_out.push_back(14);
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 16'(11 + i);
            check("fill_s_ready", s_ready, (i < 4) ? 1 : 0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("full_s_ready", s_ready, 0);
        en = 1'b1;
        seen = 0;
        prev_ready = s_ready;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (filt_start) begin
                seen = 1;
                check("ready_before_pop", prev_ready, 0);
                check("ready_after_pop", s_ready, 1);
            end
            prev_ready = s_ready;
        end
        check("fill_start_seen", seen, 1);
        wait_count("out7", 0, 7);
        en = 1'b0;

        // Underrun: zero-order hold of 55
        push_sample(55); exp_din.push_back(55); exp_out.push_back(55);
        en = 1'b1;
        wait_count("out8", 0, 8);
        exp_din.push_back(55); exp_out.push_back(55);
        wait_count("und1", 1, 1);
        wait_count("out9", 0, 9);
        en = 1'b0;
        check("und_count_1", und_count, 1);
`ifdef IIR_DRV_ERR_CNT_EN
        check("err_cnt_und", err_cnt, 1);
`endif

        // Overrun: second capture overwrites unconsumed data
        m_ready = 1'b0;
        push_sample(7); exp_din.push_back(7);
        push_sample(8); exp_din.push_back(8); exp_out.push_back(8);
        en = 1'b1;
        wait_count("ovr1", 2, 1);
        en = 1'b0;
        check("ovr_m_valid", m_valid, 1);
        check("ovr_m_data", $signed(m_data), 8);
        repeat (3) @(posedge clk); #1;
        check("ovr_count_1", ovr_count, 1);
`ifdef IIR_DRV_ERR_CNT_EN
        check("err_cnt_ovr", err_cnt, 2);
`endif
        m_ready = 1'b1;
        wait_count("out10", 0, 10);

        // Consumer handshake in the capture cycle
        m_ready = 1'b0;
        push_sample(20); exp_din.push_back(20); exp_out.push_back(20);
        push_sample(21); exp_din.push_back(21); exp_out.push_back(21);
        en = 1'b1;
        wait_start("cap_start0", t0);
        wait_start("cap_start1", t1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        en = 1'b0;
        check("cap_m_valid", m_valid, 1);
        check("cap_m_data", $signed(m_data), 21);
        check("cap_out_count", out_count, 11);
        repeat (2) @(posedge clk); #1;
        check("cap_no_overrun", ovr_count, 1);
        m_ready = 1'b1;
        wait_count("out12", 0, 12);

        // Reset during FIRE
        push_sample(33);
        en = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (filt_start) seen = 1;
        end
        check("fire_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_filt_start", filt_start, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_filt_din", filt_din, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_overrun", overrun, 0);
`ifdef IIR_DRV_ERR_CNT_EN
        check("mid_rst_err_cnt", err_cnt, 0);
`endif
        repeat (2) @(posedge clk); #1;
        exp_din.push_back(0); exp_out.push_back(0);
        rst_n = 1'b1;
        n = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (filt_start) seen = 1;
        end
        check("post_rst_start_seen", seen, 1);
        check("post_rst_start_delay", n, 8);
        wait_count("out13", 0, 13);
        en = 1'b0;
        check("und_count_2", und_count, 2);
`ifdef IIR_DRV_ERR_CNT_EN
        check("err_cnt_post_rst", err_cnt, 1);
`endif

        repeat (4) @(posedge clk); #1;
        check("din_queue_empty", exp_din.size(), 0);
        check("out_queue_empty", exp_out.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/filter_iir_stream_driver.md
# filter_iir_stream_driver

Sample-rate driver on the upstream side of the one-cycle IIR filter's strobe interface. Accepts samples on a valid/ready stream and buffers them in a small FIFO. Issues one START pulse per sample-rate tick with the sample on the filter input, then captures the filter output and presents it on a valid/ready output stream. Sits between the ADC/stream fabric and any `Filter_IIR_*_OneCyc` instance.

## Interface
- BIT_WIDTH, 16: sample width, signed two's complement, same as the filter's BIT_WIDTH.
- CLK_DIV, 100: clock cycles per sample tick; legal range ≥4.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- EN  in  1  tick counter enable.
- S_DATA  in  BIT_WIDTH  input sample.
- S_VALID  in  1  input sample valid.
- S_READY  out  1  FIFO not full.
- M_DATA  out  BIT_WIDTH  filtered sample.
- M_VALID  out  1  output register holds data.
- M_READY  in  1  consumer accepts.
- FILT_START  out  1  one-cycle strobe to filter START_FLAG.
- FILT_DIN  out  BIT_WIDTH  to filter DATA_IN.
- FILT_DOUT  in  BIT_WIDTH  from filter DATA_OUT.
- UNDERRUN  out  1  one-cycle pulse: tick with FIFO empty.
- OVERRUN  out  1  one-cycle pulse: output overwritten before accepted.
- ERR_CNT  out  16  error counter; present only with the macro.

## Operation
- Reset values: S_READY=1, M_VALID=0, M_DATA=0, FILT_START=0, FILT_DIN=0, UNDERRUN=0, OVERRUN=0, ERR_CNT=0. Counter=0, FSM=IDLE, FIFO empty, hold register=0.
- Tick counter: runs 0..CLK_DIV-1 while EN=1 and wraps to 0. tick=1 when counter==CLK_DIV-1 and EN=1. EN=0 holds the counter at its current value.
- FSM states:
  - IDLE→FIRE on tick.
  - FIRE→CAPT unconditionally.
  - CAPT→IDLE unconditionally.
- On the IDLE→FIRE edge:
  - FIFO non-empty: pop, and register the head into FILT_DIN and the hold register.
  - FIFO empty: FILT_DIN = hold register (zero-order hold), and UNDERRUN pulses in FIRE.
- FIRE: FILT_START=1 for exactly this cycle; FILT_DIN stable.
- CAPT: FILT_DOUT is sampled at the end of the cycle into M_DATA, and M_VALID is set.
  - If M_VALID=1 and M_READY=0 in CAPT, M_DATA is overwritten and OVERRUN pulses in the following cycle.
- Output handshake: M_VALID clears on M_VALID&&M_READY unless a capture happens in the same cycle. A capture has priority, so M_VALID stays 1.
- Input handshake: push on S_VALID&&S_READY; S_READY = !full, registered from FIFO occupancy.
  - A push and a pop in the same cycle: the pop takes the old head, and occupancy is unchanged.
  - A push into an empty FIFO in the tick cycle is not visible to that pop; an underrun occurs.
- EN deasserted mid-sequence: FIRE/CAPT complete normally. The FIFO keeps accepting.
- nRST asserted mid-sequence: everything returns to reset values immediately. FILT_START drops asynchronously.

## Timing
- Tick at cycle t → FILT_START high at t+1 → FILT_DOUT valid at t+2 → M_VALID high from t+3.
- FILT_START period = CLK_DIV cycles while EN=1. CLK_DIV≥4 guarantees that IDLE is revisited before the next tick.
- S_READY reflects occupancy one cycle after push/pop.
- UNDERRUN and OVERRUN are exactly one cycle wide.
- The driver ignores the filter's IIR_RDY. The filter's one-cycle latency is fixed by construction.

## Configuration
- IIR_DRV_ERR_CNT_EN defined: the ERR_CNT port exists. It increments on each UNDERRUN or OVERRUN pulse, saturates at 16'hFFFF, and is cleared only by nRST.
- IIR_DRV_ERR_CNT_EN not defined: the port and counter are absent. The pulses remain.

## Structure
- Package iir_drv_pkg:
  - FSM state type (IDLE, FIRE, CAPT).
  - Error counter width constant (16).
  - Function for the FIFO pointer width, clog2(FIFO_DEPTH).
- Sub-module iir_drv_fifo: synchronous FIFO with full/empty flags and async active-low reset, parameterised by BIT_WIDTH and FIFO_DEPTH.
- Top level: tick counter, FSM, output register, error logic.

## Test plan
- CLK_DIV=8, push 3 samples (100, -200, 300), M_READY=1 → FILT_START every 8 cycles; FILT_DIN = 100, -200, 300; with a pass-through filter model, M_DATA matches each sample 2 cycles after its FILT_START.
- FIFO_DEPTH=4, S_VALID held high, EN=0 → exactly 4 pushes, then S_READY=0; EN=1 → S_READY returns 1 the cycle after the first pop.
- Empty FIFO after sample 55 → next tick FILT_DIN=55, UNDERRUN one cycle; ERR_CNT=1 with the macro.
- M_READY=0 across two ticks → second capture overwrites M_DATA, OVERRUN pulses once, M_VALID stays 1.
- nRST pulsed low during FIRE → FILT_START drops immediately; all outputs at reset values; FIFO empty; first post-reset FILT_START after CLK_DIV cycles.
- M_READY pulse in the same cycle as a capture → M_VALID remains 1 with the new data.
